// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Handshake and data bundle for the bit-serial adder controller.
//   master : drives start/a/b/cin, observes busy/done/sum/cout
//   slave  : the adder controller side
// Optional macro: SERIAL_ADD_OVF_EN adds the signed-overflow flag ovf.
//
// Signals:
//   start  request an add (sampled only when the controller is not busy)
//   a, b   WIDTH-bit operands, captured on the accepted start
//   cin    carry-in, captured on the accepted start
//   busy   high while an add is in progress
//   done   one-cycle pulse when sum/cout are valid
//   sum    WIDTH-bit result, held until the next accepted start
//   cout   final carry-out, held with sum
//   ovf    (SERIAL_ADD_OVF_EN only) two's-complement overflow, held with sum
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: one shared full-adder cell processes WIDTH-bit operands
// LSB first, one bit per clock, with a carry flip-flop between iterations.
// An accepted start at cycle T yields a one-cycle done pulse in cycle
// T+WIDTH+1; {cout,sum} = a + b + cin.
//
// Parameters:
//   WIDTH  operand/result width, 2..32
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   bus    serial_add_ctrl_if.slave (start/a/b/cin in, busy/done/sum/cout out)
// Optional macro: SERIAL_ADD_OVF_EN adds the registered signed-overflow
//   output bus.ovf (carry into MSB XOR carry out of MSB).
// -----------------------------------------------------------------------------

// Single-bit full adder cell shared by every iteration of the serial add.
module fadder (
  output logic sum,
  output logic carry,
  input  logic x,
  input  logic y,
  input  logic z
);
  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               w_fa_sum;
  logic               w_fa_carry;
  logic               w_last;
  logic               w_accept;
  logic               w_busy;
  logic               w_done;
`ifdef SERIAL_ADD_OVF_EN
  logic               r_ovf;
`endif

  fadder u_fadder (
    .sum   (w_fa_sum),
    .carry (w_fa_carry),
    .x     (r_a_sr[0]),
    .y     (r_b_sr[0]),
    .z     (r_carry)
  );

  assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  // A new add is taken in IDLE and also in DONE, giving back-to-back operation.
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; the unused 2'b11 code falls to IDLE.
  // NOTE: the default assignment at the top keeps this block free of latches
  // even if a branch is later edited to skip an assignment.
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next_state = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next_state = w_last    ? ST_DONE : ST_RUN;
      ST_DONE: w_next_state = bus.start ? ST_RUN : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_RUN:  w_busy = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shift registers, carry FF, bit counter, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      // cout is deliberately left alone here; it holds until the next DONE.
      r_a_sr  <= bus.a;
      r_b_sr  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
      r_sum   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == ST_RUN) begin
      // Each sum bit enters at the MSB; after WIDTH shifts bit 0 is in place.
      r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_carry <= w_fa_carry;
      if (w_last) begin
        r_cout <= w_fa_carry;
`ifdef SERIAL_ADD_OVF_EN
        // r_carry is the carry into the MSB during the final bit.
        r_ovf  <= r_carry ^ w_fa_carry;
`endif
      end else begin
        // Counter stops at WIDTH-1 so it never wraps.
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed self-checking bench for serial_add_ctrl with WIDTH=8. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance falling edges until done is seen or the budget runs out.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy) nb++;
    end while (!bus.done && n < 20);
  endtask

  // Full add from IDLE: latency, busy length, result and single done pulse.
  task automatic run_add(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                         input logic cin_v, input logic [7:0] exp_sum, input logic exp_cout);
    int n, nb;
    bus.start = 1'b1;
    bus.a     = a_v;
    bus.b     = b_v;
    bus.cin   = cin_v;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n, nb);
    check({tag, "_latency"}, n + 1, 9);
    check({tag, "_busy_cycles"}, nb + 1, 8);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_cout"}, bus.cout, exp_cout);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_sum_hold"}, bus.sum, exp_sum);
  endtask

  initial begin
    int n, nb, pulses;
    logic [7:0] seen_sum;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum",  bus.sum,  0);
    check("rst_cout", bus.cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf",  bus.ovf,  0);
`endif

    // 1: basic add
    run_add("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

    // 2: carry out, then carry-in only
    run_add("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t2_start_clears_sum", bus.sum, 0);
    check("t2_start_holds_cout", bus.cout, 1);
    wait_done(n, nb);
    check("t2b_latency", n + 1, 9);
    check("t2b_sum",  bus.sum,  8'h01);
    check("t2b_cout", bus.cout, 0);

    // 4: start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    pulses   = 0;
    seen_sum = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        pulses++;
        seen_sum = bus.sum;
      end
      @(negedge clk);
    end
    check("t4_done_pulses", pulses, 1);
    check("t4_sum", seen_sum, 8'h46);
    check("t4_idle_busy", bus.busy, 0);

    // 3: back-to-back with start held through the first DONE
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    @(negedge clk);
    bus.a = 8'h80; bus.b = 8'h80;
    wait_done(n, nb);
    check("t3a_latency", n + 1, 9);
    check("t3a_sum",  bus.sum,  8'h30);
    check("t3a_cout", bus.cout, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check("t3_b2b_busy", bus.busy, 1);
    check("t3_b2b_sum_clr", bus.sum, 0);
    wait_done(n, nb);
    check("t3b_latency", n + 1, 9);
    check("t3b_sum",  bus.sum,  8'h00);
    check("t3b_cout", bus.cout, 1);
    @(negedge clk);

    // 5: reset mid-run aborts the add
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_running", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_abort_busy", bus.busy, 0);
    check("t5_abort_sum",  bus.sum,  0);
    check("t5_abort_cout", bus.cout, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done || bus.busy) pulses++;
      @(negedge clk);
    end
    check("t5_no_done", pulses, 0);
    run_add("t5_fresh", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Reset and start together: reset wins
    rst = 1'b1; bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("rst_start_busy", bus.busy, 0);
    @(negedge clk);
    check("rst_start_busy2", bus.busy, 0);

`ifdef SERIAL_ADD_OVF_EN
    // 6: signed overflow flag
    run_add("t6a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    check("t6a_ovf", bus.ovf, 1);
    run_add("t6b", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    check("t6b_ovf", bus.ovf, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences the team's single-bit full-adder cell (fadder: sum, carry, x, y, z) over WIDTH-bit operands, LSB first, one bit per clock. A carry flip-flop sits between iterations.
It gives a small start/busy/done handshake so an N-bit add shares one full-adder instance. Upstream control logic uses it wherever adder area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request an add; sampled only when not busy
a  input  WIDTH  operand A; captured on the accepted start
b  input  WIDTH  operand B; captured on the accepted start
cin  input  1  carry-in; captured on the accepted start
busy  output  1  high while an add is in progress
done  output  1  single-cycle pulse when sum/cout become valid
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  final carry-out; held with sum

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and overrides all other inputs.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry FF=0, operand shift registers=0.
- FSM states are IDLE, RUN and DONE. Use a 2-bit encoding; the unused code recovers to IDLE on the next clock.
- IDLE:
  - On start=1 at an edge, latch a, b into shift registers and cin into the carry FF.
  - Clear the counter and sum, then go to RUN.
  - busy=1 from the cycle after the accepting edge.
- RUN:
  - Each cycle, the fadder cell gets x=a_sr[0], y=b_sr[0], z=carry FF.
  - At the edge:
    - the fadder sum bit shifts into sum at MSB position [WIDTH-1], with the existing contents shifting right;
    - the fadder carry goes into the carry FF;
    - a_sr and b_sr shift right;
    - the counter increments.
  - When the counter equals WIDTH-1 at an edge, the last bit is processed and the state goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly this one cycle. sum holds the full result and cout = carry FF.
  - The next edge returns to IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back operation).
- Latency: the accepting edge at cycle T gives done=1 during cycle T+WIDTH+1. With no stalls, throughput is one add per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands and cin may change freely during RUN without effect.
- sum/cout are stable from DONE until the next accepted start, which clears sum to 0 and leaves cout unchanged until the next DONE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No truncation of the carry.
- rst asserted mid-RUN aborts the add at that edge: all registers take reset values and no done pulse is produced.
- rst and start high together: reset wins and start is dropped.
- The counter is $clog2(WIDTH) bits wide and never wraps during normal operation.

Optional Feature:
Macro: SERIAL_ADD_OVF_EN
- Defined:
  - Adds output ovf (1 bit) giving signed two's-complement overflow.
  - ovf = carry into the MSB XOR cout. The carry into the MSB is captured into a register on the final RUN cycle.
  - ovf is valid and held alongside sum/cout, resets to 0 and clears on an accepted start.
- Undefined: the ovf port and its register do not exist. All other behaviour is identical.

Test Plan:
1. Reset with WIDTH=8, then start with a=8'h5A, b=8'h3C, cin=0 → exactly 9 cycles later done=1, sum=8'h96, cout=0; busy high for 8 cycles.
2. a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=1 → sum=8'h01, cout=0.
3. Back-to-back: hold start=1 through the DONE cycle of add 8'h10+8'h20 with next operands 8'h80+8'h80 → second done 9 cycles later with sum=8'h00, cout=1. First result 8'h30 is seen during the first DONE.
4. Pulse start with 8'h0F+8'h01 while busy → ignored; the original add completes with its own operands and only one done pulse occurs.
5. Assert rst 4 cycles into RUN → next cycle busy=0, sum=0, cout=0, no done. A fresh add 8'h01+8'h01 then gives sum=8'h02.
6. With SERIAL_ADD_OVF_EN defined: 8'h7F+8'h01 → sum=8'h80, cout=0, ovf=1. Then 8'hFF+8'hFF → sum=8'hFE, cout=1, ovf=0.
